// File: rtl/round_mask_pipe_if.sv
// Request/result bundle for the rounder mask pipeline.
// Carries data/sticky only when ROUND_MASK_STICKY_EN is defined.
interface round_mask_pipe_if #(
  parameter int N    = 6,
  parameter int SHW  = 13,
  parameter int TAGW = 4
);
  localparam int W = 2 ** N;

  logic            in_valid;
  logic            in_ready;
  logic [SHW-1:0]  sh;
  logic [TAGW-1:0] tag_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    v;
  logic [W-1:0]    w;
  logic            sat;
  logic [TAGW-1:0] tag_out;
`ifdef ROUND_MASK_STICKY_EN
  logic [W-1:0]    data;
  logic            sticky;
`endif

  modport master (
`ifdef ROUND_MASK_STICKY_EN
    output data,
    input  sticky,
`endif
    output in_valid, sh, tag_in, out_ready,
    input  in_ready, out_valid, v, w, sat, tag_out
  );

  modport slave (
`ifdef ROUND_MASK_STICKY_EN
    input  data,
    output sticky,
`endif
    input  in_valid, sh, tag_in, out_ready,
    output in_ready, out_valid, v, w, sat, tag_out
  );
endinterface

// File: rtl/round_mask_pipe.sv
// Two-stage valid/ready rounder mask generator (keep/sticky masks).
// Optional ROUND_MASK_STICKY_EN adds a data input and sticky output.
module round_mask_pipe #(
  parameter int N    = 6,
  parameter int SHW  = 13,
  parameter int TAGW = 4
) (
  input logic clk,
  input logic rst,
  round_mask_pipe_if.slave bus
);
  localparam int W = 2 ** N;

  logic           s_c;
  logic [SHW-2:0] t_c;
  logic           sat_c;
  logic [N-1:0]   k_c;

  assign s_c   = bus.sh[SHW-1];
  assign t_c   = s_c ? ~bus.sh[SHW-2:0] : bus.sh[SHW-2:0];
  assign sat_c = |t_c[SHW-2:N];
  assign k_c   = sat_c ? {N{1'b1}} : t_c[N-1:0];

  logic            s1_valid;
  logic            s1_s;
  logic            s1_sat;
  logic [N-1:0]    s1_k;
  logic [TAGW-1:0] s1_tag;
`ifdef ROUND_MASK_STICKY_EN
  logic [W-1:0]    s1_data;
  logic            s2_sticky;
`endif

  logic            s2_valid;
  logic [W-1:0]    s2_v;
  logic [W-1:0]    s2_w;
  logic            s2_sat;
  logic [TAGW-1:0] s2_tag;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  logic [W-1:0] h;
  logic [W-1:0] hx;
  logic [W-1:0] u;
  logic [W-1:0] v_c;
  logic [W-1:0] w_c;

  // Negative shifts mirror the thermometer so the mask grows from the MSB.
  always_comb begin
    h  = (W'(1) << s1_k) - W'(1);
    hx = {h[W-2:0], 1'b1};
    u  = h;
    if (s1_s) begin
      for (int i = 0; i < W; i++) u[i] = hx[W-1-i];
    end
    v_c = ~u;
    w_c = s1_s ? u : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= 1'b0;
      s1_sat   <= 1'b0;
      s1_k     <= '0;
      s1_tag   <= '0;
`ifdef ROUND_MASK_STICKY_EN
      s1_data  <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_s    <= s_c;
        s1_sat  <= sat_c;
        s1_k    <= k_c;
        s1_tag  <= bus.tag_in;
`ifdef ROUND_MASK_STICKY_EN
        s1_data <= bus.data;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_v      <= '0;
      s2_w      <= '0;
      s2_sat    <= 1'b0;
      s2_tag    <= '0;
`ifdef ROUND_MASK_STICKY_EN
      s2_sticky <= 1'b0;
`endif
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_v      <= v_c;
        s2_w      <= w_c;
        s2_sat    <= s1_sat;
        s2_tag    <= s1_tag;
`ifdef ROUND_MASK_STICKY_EN
        s2_sticky <= |(s1_data & w_c);
`endif
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.v         = s2_v;
  assign bus.w         = s2_w;
  assign bus.sat       = s2_sat;
  assign bus.tag_out   = s2_tag;
`ifdef ROUND_MASK_STICKY_EN
  assign bus.sticky    = s2_sticky;
`endif

endmodule

// File: doc/round_mask_pipe.md
Name: round_mask_pipe

Overview:
- Pipelined, parametrised rounder mask generator: converts a signed shift distance into two W-bit masks, v (keep mask) and w (sticky/round-away mask), with W = 2**N.
- Sits between the exponent-adjust stage and the significand rounder; it replaces the fixed 64-bit combinational mask logic with a 2-stage valid/ready pipeline that carries a tag.
- Adds a saturation flag.

Parameters:
- N, 6, log2 of mask width; W = 2**N (default 64).
- SHW, 13, width of the signed shift input, two's complement; SHW-1 > N required.
- TAGW, 4, width of the opaque tag carried alongside each request.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  pipeline can accept a request this cycle.
- sh  input  SHW  signed shift distance.
- tag_in  input  TAGW  request tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- v  output  W  keep mask.
- w  output  W  sticky mask.
- sat  output  1  shift magnitude saturated.
- tag_out  output  TAGW  tag of the result.

Behaviour:
- Mask function, for s = sh[SHW-1]:
  - t = sh[SHW-2:0] if s=0, otherwise ~sh[SHW-2:0].
  - sat = |t[SHW-2:N].
  - k = sat ? W-1 : t[N-1:0].
  - h = thermometer with bits [k-1:0] set and all others clear; k=0 gives h=0.
  - If s=0, u = h.
  - If s=1, u = bit-reverse of {h[W-2:0],1'b1}, i.e. the top k+1 bits are set.
  - v = ~u; w = s ? u : 0.
- Stage 1 register holds s, sat, k and tag. Stage 2 register holds v, w, sat and tag.
- Latency: 2 cycles from an accepted request (in_valid&in_ready) to out_valid, when not stalled. Throughput is 1 per cycle.
- Handshake:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - stage2 advances when !out_valid or out_ready.
  - stage1 advances when !s1_valid or stage2 advances.
  - in_ready = !s1_valid or stage2 advances. in_ready has no combinational dependence on in_valid.
  - While out_valid=1 and out_ready=0, v, w, sat and tag_out hold stable.
- Full/stall: with both stages valid and out_ready=0, in_ready=0. When out_ready rises, both stages shift in the same cycle and in_ready=1.
- Simultaneous accept and retire in the same cycle is legal; no bubble is inserted.
- Reset, asserted at any time including mid-operation:
  - out_valid=0, in_ready=1, v=0, w=0, sat=0, tag_out=0.
  - All in-flight requests are discarded.
  - The first request is accepted on the first rising edge after rst deasserts.

Optional Feature:
- Macro: ROUND_MASK_STICKY_EN.
- When defined:
  - Extra input data (W bits) is captured with sh and pipelined with the request.
  - Extra output sticky (1 bit) = |(data & w) is registered in stage 2, resets to 0 and is held during stalls.
- When undefined: neither port exists and no data storage is built.

Test Plan:
- N=6, sh=0 -> after 2 cycles v=64'hFFFF_FFFF_FFFF_FFFF, w=0, sat=0.
- sh=5, then sh=-1, then sh=-3 on consecutive cycles, out_ready=1 -> three results on consecutive cycles:
  - v=~64'h1F, w=0.
  - v=64'h7FFF_FFFF_FFFF_FFFF, w=64'h8000_0000_0000_0000.
  - v=64'h1FFF_FFFF_FFFF_FFFF, w=64'hE000_0000_0000_0000.
- Saturation:
  - sh=100 -> v=64'h8000_0000_0000_0000, w=0, sat=1.
  - sh=-200 -> v=0, w=all ones, sat=1.
- Back-pressure: hold out_ready=0 for 5 cycles while issuing 3 requests with tags 1, 2, 3.
  - Only 2 are accepted; in_ready=0 afterwards.
  - Outputs stay stable during the stall.
  - Releasing out_ready yields tags 1, 2, 3 in order with no loss or duplication.
- Reset mid-stream with both stages valid -> out_valid=0 and v=w=0 immediately (asynchronous); no stale results appear after release.
- With ROUND_MASK_STICKY_EN defined: sh=-3 with data=64'h2000_0000_0000_0000 -> sticky=1; same sh with data=64'h1FFF_FFFF_FFFF_FFFF -> sticky=0.
